// File: rtl/cam_search_memory.sv
// ---------------------------------------------------------------------------
// cam_search_memory
//
// Purpose:
//   DEPTH x DW register array with single-cycle writes, a registered read
//   port and a multi-cycle content-addressable search engine. The search
//   engine compares LANES entries per clock against a latched key and
//   reports the lowest matching index through a start/busy/done handshake.
//
// Parameters:
//   DW     - entry and key width in bits
//   DEPTH  - number of entries (power of two, multiple of LANES, >= 2)
//   LANES  - entries compared per search cycle (power of two, 1..DEPTH)
//
// Ports:
//   clk, rst_n         - clock (rising edge), asynchronous active-low reset
//   wr_en, addr, din   - write strobe / address / data (array[addr] <= din)
//   rd_en              - read strobe, uses addr
//   dout, rd_valid     - registered read data and its one-cycle valid pulse
//   srch_start         - search request pulse, only honoured while idle
//   srch_key           - search key, latched when a start is accepted
//   srch_mask          - don't-care mask (1 = ignore bit), CAM_MASK_EN only
//   srch_busy          - high while scanning and in the done cycle
//   srch_done          - one-cycle completion pulse
//   srch_hit, srch_idx - search result, held until the next accepted start
//
// Configuration macro:
//   CAM_MASK_EN - when defined, adds the srch_mask port and masked matching.
//                 When undefined, matching is exact equality.
// ---------------------------------------------------------------------------
module cam_search_memory #(
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     rd_valid,
  input  logic                     srch_start,
  input  logic [DW-1:0]            srch_key,
`ifdef CAM_MASK_EN
  input  logic [DW-1:0]            srch_mask,
`endif
  output logic                     srch_busy,
  output logic                     srch_done,
  output logic                     srch_hit,
  output logic [$clog2(DEPTH)-1:0] srch_idx
);

  localparam int AW = $clog2(DEPTH);

  // Pointer value of the final group; reaching it without a match ends the
  // scan as a miss. When LANES == DEPTH the step wraps to 0 but is never
  // used, because the first group is also the last one.
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - LANES);
  localparam logic [AW-1:0] PTR_STEP = AW'(LANES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  // Storage and read port
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] dout_q, dout_d;
  logic          rd_valid_q, rd_valid_d;

  // Search engine
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] key_q, key_d;
`ifdef CAM_MASK_EN
  logic [DW-1:0] mask_q, mask_d;
`endif
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          hit_q, hit_d;
  logic [AW-1:0] idx_q, idx_d;

  // Group compare results
  logic [LANES-1:0] lane_match;
  logic             grp_hit;
  logic [AW-1:0]    grp_idx;

  // Array write and registered read. The read uses mem_q, so a read and a
  // write to the same address in one cycle return the old contents.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[addr] = din;
    end

    dout_d     = dout_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      dout_d = mem_q[addr];
    end
  end

  // Compare the current group of LANES entries against the latched key.
  // Reading mem_q means a write landing in this same cycle is not seen.
  // The downward loop leaves the lowest matching lane in grp_idx.
  always_comb begin
    lane_match = '0;
    grp_hit    = 1'b0;
    grp_idx    = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef CAM_MASK_EN
      lane_match[i] = ((mem_q[ptr_q + AW'(i)] ^ key_q) & ~mask_q) == '0;
`else
      lane_match[i] = (mem_q[ptr_q + AW'(i)] == key_q);
`endif
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_match[i]) begin
        grp_hit = 1'b1;
        grp_idx = ptr_q + AW'(i);
      end
    end
  end

  // Search FSM next-state logic. srch_done and srch_busy are computed from
  // the next state so the registered outputs line up with DONE/SCAN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    key_d   = key_q;
`ifdef CAM_MASK_EN
    mask_d  = mask_q;
`endif
    hit_d   = hit_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (srch_start) begin
          key_d   = srch_key;
`ifdef CAM_MASK_EN
          mask_d  = srch_mask;
`endif
          ptr_d   = '0;
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (grp_hit) begin
          hit_d   = 1'b1;
          idx_d   = grp_idx;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (ptr_q == LAST_PTR) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + PTR_STEP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // All state registers; reset clears the array, read port and search
  // engine so an interrupted search never produces a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      key_q      <= '0;
`ifdef CAM_MASK_EN
      mask_q     <= '0;
`endif
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      key_q      <= key_d;
`ifdef CAM_MASK_EN
      mask_q     <= mask_d;
`endif
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      idx_q      <= idx_d;
    end
  end

  assign dout      = dout_q;
  assign rd_valid  = rd_valid_q;
  assign srch_busy = busy_q;
  assign srch_done = done_q;
  assign srch_hit  = hit_q;
  assign srch_idx  = idx_q;

endmodule

// File: tb/tb_cam_search_memory.sv
// ---------------------------------------------------------------------------
// tb_cam_search_memory
//
// Self-checking bench for cam_search_memory with DW=8, DEPTH=16, LANES=4.
// Keeps a plain array copy of the memory and derives search results and
// completion latency from a linear lowest-index scan of that copy.
// Works with CAM_MASK_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_cam_search_memory;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int LANES  = 4;
  localparam int AW     = 4;
  localparam int GROUPS = DEPTH / LANES;
`ifdef CAM_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          rd_valid;
  logic          srch_start;
  logic [DW-1:0] srch_key;
  logic [DW-1:0] srch_mask;
  logic          srch_busy;
  logic          srch_done;
  logic          srch_hit;
  logic [AW-1:0] srch_idx;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [DW-1:0] mem_model [DEPTH];

  cam_search_memory #(.DW(DW), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .rd_valid   (rd_valid),
    .srch_start (srch_start),
    .srch_key   (srch_key),
`ifdef CAM_MASK_EN
    .srch_mask  (srch_mask),
`endif
    .srch_busy  (srch_busy),
    .srch_done  (srch_done),
    .srch_hit   (srch_hit),
    .srch_idx   (srch_idx)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs set after this take effect at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference search: lowest index whose bits agree with the key outside
  // the mask. Latency in cycles after the start cycle: a hit in group g
  // completes after g+2 cycles, a miss after GROUPS+1 cycles.
  function automatic void model_search(input logic [DW-1:0] key, input logic [DW-1:0] mask,
                                       output bit hit, output int idx, output int lat);
    logic [DW-1:0] eff;
    eff = MASK_ON ? mask : '0;
    hit = 1'b0;
    idx = 0;
    for (int j = 0; j < DEPTH; j++) begin
      if (!hit && (((mem_model[j] ^ key) & ~eff) == '0)) begin
        hit = 1'b1;
        idx = j;
      end
    end
    lat = hit ? (idx / LANES) + 2 : GROUPS + 1;
  endfunction

  task automatic do_write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1;
    addr  = AW'(a);
    din   = d;
    step();
    wr_en = 1'b0;
    mem_model[a] = d;
  endtask

  // Drives a search and waits (bounded) for srch_done. busy_ok collects
  // srch_busy over every cycle from k+1 through the done cycle.
  task automatic run_search(input logic [DW-1:0] key, input logic [DW-1:0] mask,
                            output int lat, output bit busy_ok);
    srch_key   = key;
    srch_mask  = mask;
    srch_start = 1'b1;
    step();
    srch_start = 1'b0;
    lat        = 1;
    busy_ok    = srch_busy;
    while (!srch_done && lat < 40) begin
      step();
      lat++;
      busy_ok = busy_ok & srch_busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    check_cnt++;
    if ({dout, rd_valid, srch_busy, srch_done, srch_hit, srch_idx} !== '0)
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {dout, rd_valid, srch_busy, srch_done, srch_hit, srch_idx});
    else pass_cnt++;
    rst_n = 1'b1;
    for (int j = 0; j < DEPTH; j++) mem_model[j] = '0;
    step();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1;
      addr  = AW'(a);
      step();
      check_cnt++;
      if (dout !== 8'h00 || rd_valid !== 1'b1)
        $display("[TB] FAIL reset_read[%0d]: got dout=%h rd_valid=%b expected 00/1", a, dout, rd_valid);
      else pass_cnt++;
    end
    rd_en = 1'b0;
    step();
    check_cnt++;
    if (rd_valid !== 1'b0)
      $display("[TB] FAIL rd_valid_drop: got %b expected 0", rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_read_write();
    int a;
    logic [DW-1:0] d;
    logic [DW-1:0] old;
    for (int n = 0; n < 6; n++) begin
      a = $urandom_range(DEPTH - 1);
      d = DW'($urandom);
      do_write(a, d);
      rd_en = 1'b1;
      addr  = AW'(a);
      step();
      rd_en = 1'b0;
      check_cnt++;
      if (dout !== mem_model[a] || rd_valid !== 1'b1)
        $display("[TB] FAIL read_back[%0d]: got %h/%b expected %h/1", a, dout, rd_valid, mem_model[a]);
      else pass_cnt++;
    end
    // dout holds while rd_en is low
    old = dout;
    step();
    check_cnt++;
    if (dout !== old)
      $display("[TB] FAIL dout_hold: got %h expected %h", dout, old);
    else pass_cnt++;
    // same-cycle read and write returns the old data
    a     = $urandom_range(DEPTH - 1);
    old   = mem_model[a];
    d     = ~old;
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = AW'(a);
    din   = d;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    mem_model[a] = d;
    check_cnt++;
    if (dout !== old)
      $display("[TB] FAIL rw_same_cycle: got %h expected %h", dout, old);
    else pass_cnt++;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check_cnt++;
    if (dout !== d)
      $display("[TB] FAIL write_visible: got %h expected %h", dout, d);
    else pass_cnt++;
  endtask

  task automatic test_search_hit();
    int lat; bit busy_ok;
    for (int j = 0; j < DEPTH; j++) do_write(j, 8'h00);
    do_write(9, 8'h5A);
    run_search(8'h5A, 8'h00, lat, busy_ok);
    check_cnt++;
    if (lat !== 4 || srch_done !== 1'b1)
      $display("[TB] FAIL hit9_latency: got %0d done=%b expected 4", lat, srch_done);
    else pass_cnt++;
    check_cnt++;
    if (srch_hit !== 1'b1 || srch_idx !== 4'd9)
      $display("[TB] FAIL hit9_result: got hit=%b idx=%0d expected 1/9", srch_hit, srch_idx);
    else pass_cnt++;
    check_cnt++;
    if (busy_ok !== 1'b1)
      $display("[TB] FAIL hit9_busy: got %b expected 1", busy_ok);
    else pass_cnt++;
    step();
    check_cnt++;
    if (srch_done !== 1'b0 || srch_busy !== 1'b0 || srch_hit !== 1'b1 || srch_idx !== 4'd9)
      $display("[TB] FAIL hit9_after: got done=%b busy=%b hit=%b idx=%0d expected 0/0/1/9",
               srch_done, srch_busy, srch_hit, srch_idx);
    else pass_cnt++;
  endtask

  task automatic test_search_lowest();
    int lat; bit busy_ok;
    do_write(2, 8'h33);
    do_write(6, 8'h33);
    run_search(8'h33, 8'h00, lat, busy_ok);
    check_cnt++;
    if (lat !== 2 || srch_hit !== 1'b1 || srch_idx !== 4'd2)
      $display("[TB] FAIL lowest: got lat=%0d hit=%b idx=%0d expected 2/1/2", lat, srch_hit, srch_idx);
    else pass_cnt++;
    step();
  endtask

  task automatic test_search_miss();
    int lat;
    srch_key   = 8'hEE;
    srch_mask  = 8'h00;
    srch_start = 1'b1;
    step();
    srch_start = 1'b0;
    lat = 1;
    step();
    lat++;
    // second start while busy, with a key that would hit; must be ignored
    srch_key   = 8'h33;
    srch_start = 1'b1;
    step();
    lat++;
    srch_start = 1'b0;
    while (!srch_done && lat < 40) begin
      step();
      lat++;
    end
    check_cnt++;
    if (lat !== 5 || srch_done !== 1'b1)
      $display("[TB] FAIL miss_latency: got %0d done=%b expected 5", lat, srch_done);
    else pass_cnt++;
    check_cnt++;
    if (srch_hit !== 1'b0 || srch_idx !== 4'd0)
      $display("[TB] FAIL miss_result: got hit=%b idx=%0d expected 0/0", srch_hit, srch_idx);
    else pass_cnt++;
    step();
    step();
    check_cnt++;
    if (srch_busy !== 1'b0 || srch_done !== 1'b0)
      $display("[TB] FAIL ignored_start: got busy=%b done=%b expected 0/0", srch_busy, srch_done);
    else pass_cnt++;
  endtask

  task automatic test_write_during_scan();
    int lat;
    bit hit; int idx; int elat;
    srch_key   = 8'h77;
    srch_mask  = 8'h00;
    srch_start = 1'b1;
    step();
    srch_start = 1'b0;
    lat = 1;
    // cycle k+1: write into a group not yet scanned
    wr_en = 1'b1;
    addr  = 4'd13;
    din   = 8'h77;
    step();
    lat++;
    wr_en = 1'b0;
    mem_model[13] = 8'h77;
    model_search(8'h77, 8'h00, hit, idx, elat);
    while (!srch_done && lat < 40) begin
      step();
      lat++;
    end
    check_cnt++;
    if (lat !== elat || srch_hit !== hit || srch_idx !== AW'(idx) || srch_idx !== 4'd13)
      $display("[TB] FAIL write_during_scan: got lat=%0d hit=%b idx=%0d expected %0d/%b/%0d",
               lat, srch_hit, srch_idx, elat, hit, idx);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_search();
    bit seen_done;
    // leave dout non-zero so the reset has something to clear
    rd_en = 1'b1;
    addr  = 4'd13;
    step();
    rd_en = 1'b0;
    srch_key   = 8'hEE;
    srch_start = 1'b1;
    step();
    srch_start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({dout, rd_valid, srch_busy, srch_done, srch_hit, srch_idx} !== '0)
      $display("[TB] FAIL reset_mid_outputs: got %h expected 0",
               {dout, rd_valid, srch_busy, srch_done, srch_hit, srch_idx});
    else pass_cnt++;
    seen_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      seen_done = seen_done | srch_done;
    end
    rst_n = 1'b1;
    for (int j = 0; j < DEPTH; j++) mem_model[j] = '0;
    for (int n = 0; n < 6; n++) begin
      step();
      seen_done = seen_done | srch_done | srch_busy;
    end
    check_cnt++;
    if (seen_done !== 1'b0)
      $display("[TB] FAIL reset_mid_no_done: got %b expected 0", seen_done);
    else pass_cnt++;
    rd_en = 1'b1;
    addr  = 4'd13;
    step();
    rd_en = 1'b0;
    check_cnt++;
    if (dout !== 8'h00)
      $display("[TB] FAIL reset_mid_mem: got %h expected 00", dout);
    else pass_cnt++;
  endtask

  task automatic test_mask();
    int lat; bit busy_ok;
    for (int j = 0; j < DEPTH; j++) do_write(j, DW'(j));
    do_write(4, 8'hA5);
    run_search(8'hA0, 8'h0F, lat, busy_ok);
    check_cnt++;
    if (MASK_ON) begin
      if (lat !== 3 || srch_hit !== 1'b1 || srch_idx !== 4'd4)
        $display("[TB] FAIL mask_hit: got lat=%0d hit=%b idx=%0d expected 3/1/4", lat, srch_hit, srch_idx);
      else pass_cnt++;
    end else begin
      if (lat !== 5 || srch_hit !== 1'b0 || srch_idx !== 4'd0)
        $display("[TB] FAIL exact_miss: got lat=%0d hit=%b idx=%0d expected 5/0/0", lat, srch_hit, srch_idx);
      else pass_cnt++;
    end
    step();
    run_search(8'h3C, 8'hFF, lat, busy_ok);
    check_cnt++;
    if (MASK_ON) begin
      if (lat !== 2 || srch_hit !== 1'b1 || srch_idx !== 4'd0)
        $display("[TB] FAIL mask_all_ones: got lat=%0d hit=%b idx=%0d expected 2/1/0", lat, srch_hit, srch_idx);
      else pass_cnt++;
    end else begin
      if (lat !== 5 || srch_hit !== 1'b0)
        $display("[TB] FAIL exact_miss2: got lat=%0d hit=%b expected 5/0", lat, srch_hit);
      else pass_cnt++;
    end
    step();
  endtask

  task automatic test_random_search();
    int lat; bit busy_ok;
    bit hit; int idx; int elat;
    logic [DW-1:0] key;
    logic [DW-1:0] mask;
    for (int n = 0; n < 10; n++) begin
      for (int w = 0; w < 3; w++) do_write($urandom_range(DEPTH - 1), DW'($urandom));
      key  = ($urandom_range(1) == 1) ? mem_model[$urandom_range(DEPTH - 1)] : DW'($urandom);
      mask = ($urandom_range(3) == 0) ? DW'($urandom) : 8'h00;
      model_search(key, mask, hit, idx, elat);
      run_search(key, mask, lat, busy_ok);
      check_cnt++;
      if (lat !== elat || srch_hit !== hit || srch_idx !== AW'(idx) || busy_ok !== 1'b1)
        $display("[TB] FAIL random_search[%0d]: key=%h got lat=%0d hit=%b idx=%0d busy=%b expected %0d/%b/%0d/1",
                 n, key, lat, srch_hit, srch_idx, busy_ok, elat, hit, idx);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit busy_ok;
    bit hit; int idx; int elat;
    logic [DW-1:0] key;
    key = mem_model[$urandom_range(DEPTH - 1)];
    model_search(key, 8'h00, hit, idx, elat);
    run_search(key, 8'h00, lat, busy_ok);
    // start raised only in the done cycle must be dropped
    srch_start = 1'b1;
    step();
    srch_start = 1'b0;
    step();
    check_cnt++;
    if (srch_busy !== 1'b0)
      $display("[TB] FAIL start_in_done: got busy=%b expected 0", srch_busy);
    else pass_cnt++;
    // two searches with the second start in the cycle right after done
    run_search(key, 8'h00, lat, busy_ok);
    step();
    key = DW'($urandom);
    model_search(key, 8'h00, hit, idx, elat);
    run_search(key, 8'h00, lat, busy_ok);
    check_cnt++;
    if (lat !== elat || srch_hit !== hit || srch_idx !== AW'(idx))
      $display("[TB] FAIL back_to_back: got lat=%0d hit=%b idx=%0d expected %0d/%b/%0d",
               lat, srch_hit, srch_idx, elat, hit, idx);
    else pass_cnt++;
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    addr       = '0;
    din        = '0;
    srch_start = 1'b0;
    srch_key   = '0;
    srch_mask  = '0;
    test_reset();
    test_read_write();
    test_search_hit();
    test_search_lowest();
    test_search_miss();
    test_write_during_scan();
    test_reset_mid_search();
    test_mask();
    test_random_search();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
